// File: rtl/aes_vector_runner_if.sv
// Board-side bundle for aes_vector_runner: synchronous vector ROM read port
// plus the AES core operand / start / ready handshake.
interface aes_vector_runner_if #(
    parameter int DATA_W = 128,
    parameter int IDX_W  = 4
);
    logic [IDX_W-1:0]  vec_addr;
    logic [DATA_W-1:0] vec_key;
    logic [DATA_W-1:0] vec_pt;
    logic [DATA_W-1:0] vec_ct;
    logic              core_start;
    logic              core_enc_dec;
    logic [DATA_W-1:0] core_data_in;
    logic [DATA_W-1:0] core_key_in;
    logic [DATA_W-1:0] core_data_out;
    logic              core_ready;

    modport master (
        output vec_addr,
        input  vec_key, vec_pt, vec_ct,
        output core_start, core_enc_dec, core_data_in, core_key_in,
        input  core_data_out, core_ready
    );

    modport slave (
        input  vec_addr,
        output vec_key, vec_pt, vec_ct,
        input  core_start, core_enc_dec, core_data_in, core_key_in,
        output core_data_out, core_ready
    );
endinterface

// File: rtl/aes_vector_runner.sv
// Sweeps a synchronous vector ROM through the AES core and tallies pass/fail results.
// Define AES_RUNNER_DECRYPT_EN to follow each encrypt with a decrypt of the same vector.
//
// state     | meaning
// IDLE      | waiting for run
// LOAD      | ROM read in flight for vec_addr
// START     | latch operands, pulse core_start
// WAIT_BUSY | waiting for core_ready to drop
// WAIT_DONE | waiting for core_ready to return, capture result
// CHECK     | compare last_result with expected vector
// NEXT      | pick next mode / index or finish
// DONE      | sweep finished, done/pass held
module aes_vector_runner #(
    parameter int  NUM_VEC = 16,
    parameter int  DATA_W  = 128,
    parameter int  TIMEOUT = 1024,
    localparam int IDX_W   = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1,
    localparam int CNT_W   = $clog2(2*NUM_VEC+1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic                abort,
    aes_vector_runner_if.master bus,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [CNT_W-1:0]    pass_cnt,
    output logic [CNT_W-1:0]    fail_cnt,
    output logic [IDX_W-1:0]    first_fail_idx,
    output logic                first_fail_dec,
    output logic                timeout_flag,
    output logic [IDX_W-1:0]    cur_idx,
    output logic [DATA_W-1:0]   last_result
);
    localparam int TMR_W = $clog2(TIMEOUT+1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC-1);
`ifdef AES_RUNNER_DECRYPT_EN
    localparam bit DEC_EN = 1'b1;
`else
    localparam bit DEC_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, CHECK, NEXT, DONE} state_t;

    state_t           state, state_nxt;
    logic             mode;          // 1 = encrypt
    logic [TMR_W-1:0] tmr;
    logic             accept_run, abort_now, tmo, count_pass, count_fail;

    assign bus.core_enc_dec = mode;

    always_comb begin
        state_nxt  = state;
        accept_run = 1'b0;
        abort_now  = 1'b0;
        tmo        = 1'b0;
        count_pass = 1'b0;
        count_fail = 1'b0;
        case (state)
            IDLE, DONE: if (run && !abort) begin
                state_nxt  = LOAD;
                accept_run = 1'b1;
            end
            LOAD:  state_nxt = START;
            START: state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tmr == '0) begin
                    tmo       = 1'b1;
                    state_nxt = NEXT;
                end else if (!bus.core_ready) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (tmr == '0) begin
                    tmo       = 1'b1;
                    state_nxt = NEXT;
                end else if (bus.core_ready) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                state_nxt = NEXT;
                if (last_result == (mode ? bus.vec_ct : bus.vec_pt)) count_pass = 1'b1;
                else                                                 count_fail = 1'b1;
            end
            NEXT: begin
                if (DEC_EN && mode)          state_nxt = LOAD;
                else if (cur_idx == LAST_IDX) state_nxt = DONE;
                else                          state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
        if (tmo) count_fail = 1'b1;
        // abort beats everything, including a pending count or run
        if (abort && state != IDLE && state != DONE) begin
            abort_now  = 1'b1;
            tmo        = 1'b0;
            count_pass = 1'b0;
            count_fail = 1'b0;
            state_nxt  = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            mode             <= 1'b0;
            tmr              <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            pass_cnt         <= '0;
            fail_cnt         <= '0;
            first_fail_idx   <= '0;
            timeout_flag     <= 1'b0;
            cur_idx          <= '0;
            last_result      <= '0;
            bus.vec_addr     <= '0;
            bus.core_start   <= 1'b0;
            bus.core_data_in <= '0;
            bus.core_key_in  <= '0;
`ifdef AES_RUNNER_DECRYPT_EN
            first_fail_dec   <= 1'b0;
`endif
        end else begin
            state          <= state_nxt;
            busy           <= (state_nxt != IDLE) && (state_nxt != DONE);
            bus.core_start <= 1'b0;
            if (abort_now) begin
                done <= 1'b0;
                pass <= 1'b0;
            end
            if (accept_run) begin
                bus.vec_addr   <= '0;
                cur_idx        <= '0;
                pass_cnt       <= '0;
                fail_cnt       <= '0;
                timeout_flag   <= 1'b0;
                first_fail_idx <= '0;
`ifdef AES_RUNNER_DECRYPT_EN
                first_fail_dec <= 1'b0;
`endif
                done           <= 1'b0;
                pass           <= 1'b0;
                mode           <= 1'b1;
            end
            if (!abort_now) begin
                case (state)
                    START: begin
                        bus.core_key_in  <= bus.vec_key;
                        bus.core_data_in <= mode ? bus.vec_pt : bus.vec_ct;
                        bus.core_start   <= 1'b1;
                        tmr              <= TMR_W'(TIMEOUT-1);
                    end
                    WAIT_BUSY, WAIT_DONE: begin
                        if (tmr != '0) tmr <= tmr - TMR_W'(1);
                        if (tmo) timeout_flag <= 1'b1;
                        if (state == WAIT_DONE && state_nxt == CHECK) last_result <= bus.core_data_out;
                    end
                    NEXT: begin
                        if (state_nxt == DONE) begin
                            done <= 1'b1;
                            pass <= (fail_cnt == '0);
                        end else if (DEC_EN && mode) begin
                            mode <= 1'b0;
                        end else begin
                            cur_idx      <= cur_idx + IDX_W'(1);
                            bus.vec_addr <= bus.vec_addr + IDX_W'(1);
                            mode         <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            if (count_pass) pass_cnt <= pass_cnt + CNT_W'(1);
            if (count_fail) begin
                fail_cnt <= fail_cnt + CNT_W'(1);
                if (fail_cnt == '0) begin
                    first_fail_idx <= cur_idx;
`ifdef AES_RUNNER_DECRYPT_EN
                    first_fail_dec <= ~mode;
`endif
                end
            end
        end
    end

`ifndef AES_RUNNER_DECRYPT_EN
    assign first_fail_dec = 1'b0;
`endif
endmodule
